mod_74x08_3: RTL and testbench

- Three independent 2-input AND gates, one per channel (a partial 74x08 quad-AND package). Used as glue logic in 74xx-style board models.
- Default mode is purely combinational. A parameter selects an optional registered output stage that uses the single clock and the asynchronous reset.

---
 rtl/ttl_pkg.sv | 12 +
 rtl/ttl_and2_cell.sv | 44 ++++
 rtl/mod_74x08_3.sv | 50 +++++
 tb/tb_mod_74x08_3.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared constants for 74xx-style glue-logic models: output-stage mode selection.
// No logic; imported by the gate cells and package tops.
package ttl_pkg;

  localparam int TTL_COMB = 0;
  localparam int TTL_REG  = 1;

  function automatic bit ttl_mode_ok(input int mode);
    return (mode == TTL_COMB) || (mode == TTL_REG);
  endfunction

endpackage

// File: rtl/ttl_and2_cell.sv
// One 2-input AND gate with an optional output flop; latency 0 (comb) or 1 cycle (reg).
// No backpressure: output is either the live gate value or the last sampled one.
module ttl_and2_cell
  import ttl_pkg::*;
#(
  parameter int   REG_OUT   = TTL_COMB,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  logic w_and;

  // Plain & keeps 4-state semantics: a 0 on either leg dominates x/z.
  assign w_and = i_a & i_b;

  if (!ttl_mode_ok(REG_OUT)) begin : g_bad_mode
    $error("ttl_and2_cell: REG_OUT must be 0 or 1, got %0d", REG_OUT);
  end

  if (REG_OUT == TTL_REG) begin : g_reg
    logic r_y;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_y <= RESET_VAL;
      end else begin
        r_y <= w_and;
      end
    end

    assign o_y = r_y;
  end else begin : g_comb
    // Clock and reset are intentionally ignored in combinational mode.
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_y      = w_and;
  end

endmodule

// File: rtl/mod_74x08_3.sv
// Three independent 2-input AND gates (partial 74x08); latency 0 or 1 cycle per REG_OUT.
// No backpressure; clk/rst sit last so legacy 9-port positional instances still bind.
module mod_74x08_3
  import ttl_pkg::*;
#(
  parameter int   REG_OUT   = TTL_COMB,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic A1,
  input  logic B1,
  input  logic A2,
  input  logic B2,
  input  logic A3,
  input  logic B3,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  input  logic clk,
  input  logic rst
);

  logic [2:0] w_a;
  logic [2:0] w_b;
  logic [2:0] w_y;

  if (!ttl_mode_ok(REG_OUT)) begin : g_bad_mode
    $error("mod_74x08_3: REG_OUT must be 0 or 1, got %0d", REG_OUT);
  end

  assign w_a = {A3, A2, A1};
  assign w_b = {B3, B2, B1};

  for (genvar g = 0; g < 3; g++) begin : g_gate
    ttl_and2_cell #(
      .REG_OUT   (REG_OUT),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .i_clk (clk),
      .i_rst (rst),
      .i_a   (w_a[g]),
      .i_b   (w_b[g]),
      .o_y   (w_y[g])
    );
  end

  assign Y1 = w_y[0];
  assign Y2 = w_y[1];
  assign Y3 = w_y[2];

endmodule

// File: tb/tb_mod_74x08_3.sv
// Bench for mod_74x08_3: one combinational and one registered instance.
// Stimulus pushes expected {Y1,Y2,Y3} into a queue; a monitor pops and compares on each sample event.
module tb_mod_74x08_3;

  logic clk;
  logic rst_c;
  logic rst_r;
  logic [5:0] comb_in;   // {A1,B1,A2,B2,A3,B3}
  logic [5:0] reg_in;
  logic c_y1, c_y2, c_y3;
  logic r_y1, r_y2, r_y3;

  typedef struct {
    string      tag;
    bit         sel_reg;
    logic [2:0] exp_y;   // {Y1,Y2,Y3}
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mod_74x08_3 #(.REG_OUT(0), .RESET_VAL(1'b0)) u_comb (
    .A1(comb_in[5]), .B1(comb_in[4]), .A2(comb_in[3]), .B2(comb_in[2]),
    .A3(comb_in[1]), .B3(comb_in[0]),
    .Y1(c_y1), .Y2(c_y2), .Y3(c_y3),
    .clk(clk), .rst(rst_c)
  );

  mod_74x08_3 #(.REG_OUT(1), .RESET_VAL(1'b0)) u_reg (
    .A1(reg_in[5]), .B1(reg_in[4]), .A2(reg_in[3]), .B2(reg_in[2]),
    .A3(reg_in[1]), .B3(reg_in[0]),
    .Y1(r_y1), .Y2(r_y2), .Y3(r_y3),
    .clk(clk), .rst(rst_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares the selected instance's outputs against the oldest queued expectation.
  initial begin
    exp_t       e;
    logic [2:0] act;
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = e.sel_reg ? {r_y1, r_y2, r_y3} : {c_y1, c_y2, c_y3};
        n_cmp++;
        if (act !== e.exp_y) begin
          n_fail++;
          $display("FAIL %s: got Y1Y2Y3=%b expected %b at t=%0t", e.tag, act, e.exp_y, $time);
        end
      end
    end
  end

  task automatic push_and_sample(input string tag, input bit sel_reg, input logic [2:0] exp_y);
    exp_t e;
    e.tag     = tag;
    e.sel_reg = sel_reg;
    e.exp_y   = exp_y;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  // Combinational step: apply, settle, sample mid-hold, finish the 20-unit hold.
  task automatic comb_step(input string tag, input logic [5:0] in, input logic [2:0] exp_y);
    comb_in = in;
    #10;
    push_and_sample(tag, 1'b0, exp_y);
    #10;
  endtask

  task automatic reg_check(input string tag, input logic [2:0] exp_y);
    push_and_sample(tag, 1'b1, exp_y);
  endtask

  typedef struct {
    string      tag;
    logic [5:0] in;
    logic [2:0] exp_y;
  } vec_t;

  vec_t comb_vecs[$];

  initial begin
    rst_c   = 1'b0;
    rst_r   = 1'b0;
    comb_in = 6'b000000;
    reg_in  = 6'b111111;   // registered instance settles to 111 during the comb phase

    comb_vecs = '{
      '{"c_init",   6'b000000, 3'b000},
      '{"g1_11",    6'b110000, 3'b100},
      '{"g1_01",    6'b010000, 3'b000},
      '{"g1_10",    6'b100000, 3'b000},
      '{"g1_00",    6'b000000, 3'b000},
      '{"g2_11",    6'b001100, 3'b010},
      '{"g2_01",    6'b000100, 3'b000},
      '{"g2_10",    6'b001000, 3'b000},
      '{"g2_00",    6'b000000, 3'b000},
      '{"g3_11",    6'b000011, 3'b001},
      '{"g3_01",    6'b000001, 3'b000},
      '{"g3_10",    6'b000010, 3'b000},
      '{"g3_00",    6'b000000, 3'b000},
      '{"iso_a",    6'b111111, 3'b111},
      '{"iso_b",    6'b111011, 3'b101},
      '{"iso_c",    6'b110111, 3'b101},
      '{"iso_d",    6'b111100, 3'b110},
      '{"iso_e",    6'b110110, 3'b100},
      '{"iso_f",    6'b110000, 3'b100},
      '{"x_a2_0",   6'b000x00, 3'b000},
      '{"x_b3_0",   6'b0000x0, 3'b000},
      '{"x_a1_0",   6'b0x0000, 3'b000}
    };

    foreach (comb_vecs[i]) begin
      // Toggle the comb instance's reset during the isolation block; it must be ignored.
      rst_c = (comb_vecs[i].tag.substr(0, 2) == "iso") ? ~rst_c : 1'b0;
      comb_step(comb_vecs[i].tag, comb_vecs[i].in, comb_vecs[i].exp_y);
    end

    // Registered instance.
    @(negedge clk);
    reg_check("r_pre", 3'b111);
    #1 rst_r = 1'b1;
    #1 reg_check("r_rst_async", 3'b000);
    @(negedge clk);
    reg_check("r_rst_hold", 3'b000);

    reg_in = 6'b000000;
    rst_r  = 1'b0;
    @(negedge clk);
    reg_check("r_rel_zero", 3'b000);

    reg_in = 6'b110000;
    #1 reg_check("r_lat_before", 3'b000);
    @(negedge clk);
    reg_check("r_lat_after", 3'b100);

    reg_in = 6'b111111;
    @(negedge clk);
    reg_check("r_all_one", 3'b111);

    #1 rst_r = 1'b1;
    #1 reg_check("r_pulse_now", 3'b000);
    #1 rst_r = 1'b0;
    #1 reg_check("r_pulse_fell", 3'b000);
    @(negedge clk);
    reg_check("r_pulse_recover", 3'b111);

    @(posedge clk);
    rst_r = 1'b1;
    #1 reg_check("r_rst_on_edge", 3'b000);
    @(negedge clk);
    rst_r = 1'b0;
    @(negedge clk);
    reg_check("r_edge_recover", 3'b111);

    reg_in = 6'b111100;
    #1 reg_check("r_fall_before", 3'b111);
    @(negedge clk);
    reg_check("r_fall_after", 3'b110);

    // Drain with a bounded wait; anything left unmatched counts against the run.
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
      n_fail += exp_q.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
